// File: rtl/jpeg_pkg.sv
// Shared JPEG entropy-path types: chroma tags, per-pair context and
// block/MCU geometry helpers used by the block sequencer and its skid FIFO.
package jpeg_pkg;

    localparam int BLK_PAIRS = 32;
    localparam int BLKS_420  = 6;
    localparam int BLKS_444  = 3;

    typedef enum logic [1:0] {
        Y  = 2'd0,
        CB = 2'd1,
        CR = 2'd2
    } chroma_t;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_BLK = 2'd1,
        ST_READ     = 2'd2,
        ST_FLUSH    = 2'd3
    } seq_state_t;

    typedef struct packed {
        logic [4:0] cnt;
        chroma_t    chroma;
        logic       last_mcu;
    } pair_ctx_t;

    // Component carried by a block, from its position inside the MCU.
    function automatic chroma_t blk_chroma(input logic [2:0] blk_idx, input logic is_420);
        chroma_t c;
        c = Y;
        if (is_420) begin
            case (blk_idx)
                3'd4:    c = CB;
                3'd5:    c = CR;
                default: c = Y;
            endcase
        end else begin
            case (blk_idx)
                3'd1:    c = CB;
                3'd2:    c = CR;
                default: c = Y;
            endcase
        end
        return c;
    endfunction

    // Index of the final (Cr) block of an MCU.
    function automatic logic [2:0] blk_wrap(input logic is_420);
        return is_420 ? 3'(BLKS_420 - 1) : 3'(BLKS_444 - 1);
    endfunction

endpackage

// File: rtl/entropy_skid_fifo.sv
// Two-entry skid FIFO for a 1-cycle-latency read source feeding a stallable sink.
// Context travels with each read; the credit output counts reads still in flight.
module entropy_skid_fifo
    import jpeg_pkg::*;
#(
    parameter int DATA_W = 22
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              issue,
    input  pair_ctx_t         issue_ctx,
    input  logic [DATA_W-1:0] rd_data,
    input  logic              pop,
    output logic              head_valid,
    output logic [DATA_W-1:0] head_data,
    output pair_ctx_t         head_ctx,
    output logic              credit_ok
);

    logic              pend_q, pend_d;
    pair_ctx_t         pend_ctx_q, pend_ctx_d;
    logic              v0_q, v0_d, v1_q, v1_d;
    logic [DATA_W-1:0] d0_q, d0_d, d1_q, d1_d;
    pair_ctx_t         c0_q, c0_d, c1_q, c1_d;
    logic              pop_s;
    logic [2:0]        occ_s;

    // Credit: entries held after this cycle's pop plus the read landing now.
    // Counting the pop keeps a full 1 pair/cycle stream with only two entries.
    always_comb begin
        pop_s     = pop & v0_q;
        occ_s     = {2'b00, v0_q} + {2'b00, v1_q} + {2'b00, pend_q} - {2'b00, pop_s};
        credit_ok = (occ_s < 3'd2);
    end

    // Entry update: pop shifts the skid entry to the head, arriving data fills the first free slot.
    always_comb begin
        v0_d       = v0_q;
        v1_d       = v1_q;
        d0_d       = d0_q;
        d1_d       = d1_q;
        c0_d       = c0_q;
        c1_d       = c1_q;
        pend_d     = issue;
        pend_ctx_d = issue_ctx;
        if (pop_s) begin
            if (v1_q) begin
                d0_d = d1_q;
                c0_d = c1_q;
                v1_d = 1'b0;
            end else begin
                v0_d = 1'b0;
            end
        end else begin
            v0_d = v0_q;
        end
        if (pend_q) begin
            if (!v0_d) begin
                v0_d = 1'b1;
                d0_d = rd_data;
                c0_d = pend_ctx_q;
            end else begin
                v1_d = 1'b1;
                d1_d = rd_data;
                c1_d = pend_ctx_q;
            end
        end else begin
            d1_d = d1_q;
        end
    end

    // Storage and in-flight tracking; reset also drops any read still in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            pend_q     <= 1'b0;
            pend_ctx_q <= '0;
            v0_q       <= 1'b0;
            v1_q       <= 1'b0;
            d0_q       <= '0;
            d1_q       <= '0;
            c0_q       <= '0;
            c1_q       <= '0;
        end else begin
            pend_q     <= pend_d;
            pend_ctx_q <= pend_ctx_d;
            v0_q       <= v0_d;
            v1_q       <= v1_d;
            d0_q       <= d0_d;
            d1_q       <= d1_d;
            c0_q       <= c0_d;
            c1_q       <= c1_d;
        end
    end

    assign head_valid = v0_q;
    assign head_data  = d0_q;
    assign head_ctx   = c0_q;

endmodule

// File: rtl/entropy_block_sequencer.sv
// Walks the MCU/block structure of a frame, reads each 32-pair block from the
// coefficient buffer and hands context-tagged pairs to the entropy stage.
module entropy_block_sequencer
    import jpeg_pkg::*;
#(
    parameter int MCU_CNT_W = 16,
    parameter int COEFF_W   = 11
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      cfg_420,
    input  logic [MCU_CNT_W-1:0]      cfg_mcu_count,
    input  logic                      blk_avail,
    output logic                      blk_release,
    output logic                      rd_en,
    output logic [4:0]                rd_addr,
    input  logic [2*COEFF_W-1:0]      rd_data,
    output logic signed [COEFF_W-1:0] q [2],
    output logic                      q_valid,
    input  logic                      q_hold,
    output logic [4:0]                q_cnt,
    output logic [1:0]                q_chroma,
    output logic                      q_last_mcu,
    output logic                      busy,
    output logic                      frame_done
);

    seq_state_t           state_q, state_d;
    logic                 cfg_420_q, cfg_420_d;
    logic [MCU_CNT_W-1:0] cfg_mcu_q, cfg_mcu_d;
    logic [2:0]           blk_idx_q, blk_idx_d;
    logic [MCU_CNT_W-1:0] mcu_idx_q, mcu_idx_d;
    logic [4:0]           rd_addr_q, rd_addr_d;
    logic                 busy_q, busy_d;
    logic                 frame_done_q, frame_done_d;

    logic                 rd_en_s;
    logic                 blk_release_s;
    logic                 credit_ok_s;
    logic                 head_valid_s;
    logic [2*COEFF_W-1:0] head_data_s;
    pair_ctx_t            head_ctx_s;
    pair_ctx_t            issue_ctx_s;
    logic                 pop_s;
    logic                 last_blk_s;
    logic                 blk_at_wrap_s;
    logic                 pair31_done_s;

    // Context is fixed at read issue; the last block of a frame is always its Cr block.
    always_comb begin
        blk_at_wrap_s      = (blk_idx_q == blk_wrap(cfg_420_q));
        last_blk_s         = blk_at_wrap_s && (mcu_idx_q == cfg_mcu_q);
        issue_ctx_s.cnt    = rd_addr_q;
        issue_ctx_s.chroma = blk_chroma(blk_idx_q, cfg_420_q);
        issue_ctx_s.last_mcu = last_blk_s;
        pop_s              = head_valid_s & ~q_hold;
        pair31_done_s      = pop_s && (head_ctx_s.cnt == 5'(BLK_PAIRS - 1));
    end

    // Next-state and strobe logic for the frame walk.
    always_comb begin
        state_d       = state_q;
        cfg_420_d     = cfg_420_q;
        cfg_mcu_d     = cfg_mcu_q;
        blk_idx_d     = blk_idx_q;
        mcu_idx_d     = mcu_idx_q;
        rd_addr_d     = rd_addr_q;
        busy_d        = busy_q;
        frame_done_d  = 1'b0;
        rd_en_s       = 1'b0;
        blk_release_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    cfg_420_d = cfg_420;
                    cfg_mcu_d = cfg_mcu_count;
                    blk_idx_d = 3'd0;
                    mcu_idx_d = '0;
                    busy_d    = 1'b1;
                    state_d   = ST_WAIT_BLK;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT_BLK: begin
                if (blk_avail) begin
                    rd_addr_d = 5'd0;
                    state_d   = ST_READ;
                end else begin
                    state_d = ST_WAIT_BLK;
                end
            end
            ST_READ: begin
                if (credit_ok_s) begin
                    rd_en_s   = 1'b1;
                    rd_addr_d = rd_addr_q + 5'd1;
                    if (rd_addr_q == 5'(BLK_PAIRS - 1)) begin
                        state_d = ST_FLUSH;
                    end else begin
                        state_d = ST_READ;
                    end
                end else begin
                    state_d = ST_READ;
                end
            end
            ST_FLUSH: begin
                if (pair31_done_s) begin
                    blk_release_s = 1'b1;
                    if (last_blk_s) begin
                        frame_done_d = 1'b1;
                        busy_d       = 1'b0;
                        state_d      = ST_IDLE;
                    end else begin
                        state_d = ST_WAIT_BLK;
                        if (blk_at_wrap_s) begin
                            blk_idx_d = 3'd0;
                            mcu_idx_d = mcu_idx_q + {{(MCU_CNT_W-1){1'b0}}, 1'b1};
                        end else begin
                            blk_idx_d = blk_idx_q + 3'd1;
                        end
                    end
                end else begin
                    state_d = ST_FLUSH;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Sequencer state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cfg_420_q    <= 1'b0;
            cfg_mcu_q    <= '0;
            blk_idx_q    <= 3'd0;
            mcu_idx_q    <= '0;
            rd_addr_q    <= 5'd0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cfg_420_q    <= cfg_420_d;
            cfg_mcu_q    <= cfg_mcu_d;
            blk_idx_q    <= blk_idx_d;
            mcu_idx_q    <= mcu_idx_d;
            rd_addr_q    <= rd_addr_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    entropy_skid_fifo #(
        .DATA_W(2*COEFF_W)
    ) u_skid (
        .clk       (clk),
        .reset     (reset),
        .issue     (rd_en_s),
        .issue_ctx (issue_ctx_s),
        .rd_data   (rd_data),
        .pop       (pop_s),
        .head_valid(head_valid_s),
        .head_data (head_data_s),
        .head_ctx  (head_ctx_s),
        .credit_ok (credit_ok_s)
    );

    assign rd_en       = rd_en_s;
    assign rd_addr     = rd_addr_q;
    assign blk_release = blk_release_s;
    assign busy        = busy_q;
    assign frame_done  = frame_done_q;
    assign q_valid     = head_valid_s;
    assign q[0]        = $signed(head_data_s[COEFF_W-1:0]);
    assign q[1]        = $signed(head_data_s[2*COEFF_W-1:COEFF_W]);
    assign q_cnt       = head_ctx_s.cnt;
    assign q_chroma    = head_ctx_s.chroma;
    assign q_last_mcu  = head_ctx_s.last_mcu;

endmodule

// File: tb/tb_entropy_block_sequencer.sv
// Randomized bench for entropy_block_sequencer: a buffer model supplies
// per-block coefficient words and a frame-level queue model predicts every pair.
module tb_entropy_block_sequencer;

    logic               clk = 1'b0;
    logic               reset;
    logic               start;
    logic               cfg_420;
    logic [15:0]        cfg_mcu_count;
    logic               blk_avail;
    logic               blk_release;
    logic               rd_en;
    logic [4:0]         rd_addr;
    logic [21:0]        rd_data = 22'd0;
    logic signed [10:0] q [2];
    logic               q_valid;
    logic               q_hold = 1'b0;
    logic [4:0]         q_cnt;
    logic [1:0]         q_chroma;
    logic               q_last_mcu;
    logic               busy;
    logic               frame_done;

    entropy_block_sequencer #(.MCU_CNT_W(16), .COEFF_W(11)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .cfg_420      (cfg_420),
        .cfg_mcu_count(cfg_mcu_count),
        .blk_avail    (blk_avail),
        .blk_release  (blk_release),
        .rd_en        (rd_en),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .q            (q),
        .q_valid      (q_valid),
        .q_hold       (q_hold),
        .q_cnt        (q_cnt),
        .q_chroma     (q_chroma),
        .q_last_mcu   (q_last_mcu),
        .busy         (busy),
        .frame_done   (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  cnt;
        logic [1:0]  chroma;
        logic        last;
        logic [21:0] data;
    } exp_t;

    exp_t        exp_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int unsigned salt;
    int unsigned blk_seq = 0;
    int          hold_pct = 0;
    int          gap_cfg = 0;
    int          gap_left = 0;
    logic        exp_busy = 1'b0;
    logic        exp_done = 1'b0;
    logic        chk_rst = 1'b0;
    int          iss = 0;
    int          acc = 0;
    int          rel = 0;
    logic        prev_hold = 1'b0;
    logic [4:0]  prev_cnt;
    logic [1:0]  prev_chroma;
    logic        prev_last;
    logic [21:0] prev_data;
    int          fr_acc = 0;
    int          fr_last = 0;
    int          fr_rel = 0;
    int          fr_hist[3];
    int          fr_first_cnt = -1;
    int          fr_first_chroma = -1;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d required %0d at %0t", nm, got, exp, $time);
        end
    endtask

    function automatic logic [21:0] coef_word(input int unsigned blk, input int unsigned k);
        logic [31:0] h;
        h = salt ^ (blk * 32'h9E3779B1) ^ (k * 32'h00009E37);
        return h[21:0];
    endfunction

    // Frame model: block order, component and last-MCU tag from the MCU layout.
    task automatic push_frame(input logic is420, input int mcu_m1);
        int   per;
        int   nblk;
        int   bi;
        exp_t e;
        per  = is420 ? 6 : 3;
        nblk = per * (mcu_m1 + 1);
        for (int b = 0; b < nblk; b++) begin
            bi = b % per;
            if (is420) e.chroma = (bi < 4) ? 2'd0 : ((bi == 4) ? 2'd1 : 2'd2);
            else       e.chroma = 2'(bi);
            e.last = (b == nblk - 1);
            for (int k = 0; k < 32; k++) begin
                e.cnt  = 5'(k);
                e.data = coef_word(blk_seq + 32'(b), 32'(k));
                exp_q.push_back(e);
            end
        end
    endtask

    // Coefficient buffer: data for the addressed pair of the current bank, one cycle after rd_en.
    always @(posedge clk) begin
        if (rd_en) rd_data <= coef_word(blk_seq, 32'(rd_addr));
        else       rd_data <= 22'($urandom);
    end

    // Entropy-stage back-pressure.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            q_hold = (hold_pct > 0) && ($urandom_range(99) < 32'(hold_pct));
        end
    end

    // Per-cycle compare against the model, plus bank availability handling.
    always @(negedge clk) begin
        logic pop_now;
        logic acc_final;
        logic busy_now;
        logic exp_rel;
        logic in_gap;
        exp_t e;
        if (reset) begin
            exp_q.delete();
            exp_busy  = 1'b0;
            exp_done  = 1'b0;
            iss       = 0;
            acc       = 0;
            rel       = 0;
            prev_hold = 1'b0;
            gap_left  = 0;
            blk_avail = 1'b1;
            chk_rst   = 1'b1;
        end else begin
            if (chk_rst) begin
                check("rst_q_valid", 32'(q_valid), 32'd0);
                check("rst_busy", 32'(busy), 32'd0);
                check("rst_rd_en", 32'(rd_en), 32'd0);
                check("rst_rd_addr", 32'(rd_addr), 32'd0);
                check("rst_release", 32'(blk_release), 32'd0);
                check("rst_done", 32'(frame_done), 32'd0);
                check("rst_q_cnt", 32'(q_cnt), 32'd0);
                chk_rst = 1'b0;
            end
            busy_now = exp_busy;
            in_gap   = (gap_left > 0);
            check("busy", 32'(busy), 32'(exp_busy));
            check("frame_done", 32'(frame_done), 32'(exp_done));
            pop_now = q_valid && !q_hold;
            if (q_valid) begin
                if (exp_q.size() == 0) begin
                    check("q_valid_spurious", 32'(q_valid), 32'd0);
                end else begin
                    e = exp_q[0];
                    check("q_cnt", 32'(q_cnt), 32'(e.cnt));
                    check("q_chroma", 32'(q_chroma), 32'(e.chroma));
                    check("q_last_mcu", 32'(q_last_mcu), 32'(e.last));
                    check("q_data", 32'({q[1], q[0]}), 32'(e.data));
                end
                if (prev_hold) begin
                    check("hold_cnt", 32'(q_cnt), 32'(prev_cnt));
                    check("hold_chroma", 32'(q_chroma), 32'(prev_chroma));
                    check("hold_last", 32'(q_last_mcu), 32'(prev_last));
                    check("hold_data", 32'({q[1], q[0]}), 32'(prev_data));
                end
            end else if (prev_hold) begin
                check("hold_valid", 32'(q_valid), 32'd1);
            end
            exp_rel = pop_now && (exp_q.size() > 0) && (exp_q[0].cnt == 5'd31);
            check("blk_release", 32'(blk_release), 32'(exp_rel));
            if (in_gap) begin
                check("gap_q_valid", 32'(q_valid), 32'd0);
                check("gap_rd_en", 32'(rd_en), 32'd0);
            end
            if (rd_en) begin
                check("rd_credit", 32'((iss - acc - int'(pop_now)) <= 1), 32'd1);
                check("rd_addr", 32'(rd_addr), 32'(iss % 32));
                check("rd_bank", 32'(iss / 32), 32'(rel));
                check("rd_in_frame", 32'(busy_now), 32'd1);
                iss++;
            end
            acc_final = 1'b0;
            if (pop_now && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                if (fr_acc == 0) begin
                    fr_first_cnt    = int'(q_cnt);
                    fr_first_chroma = int'(q_chroma);
                end
                fr_acc++;
                if (q_last_mcu) fr_last++;
                if (q_chroma < 2'd3) fr_hist[q_chroma]++;
                acc++;
                if (exp_q.size() == 0) acc_final = 1'b1;
            end
            if (blk_release) begin
                rel++;
                fr_rel++;
                blk_seq++;
                if (gap_cfg > 0) begin
                    blk_avail = 1'b0;
                    gap_left  = gap_cfg;
                end
            end else if (gap_left > 0) begin
                gap_left--;
                if (gap_left == 0) blk_avail = 1'b1;
            end
            exp_done = acc_final;
            if (acc_final) exp_busy = 1'b0;
            if (start && !busy_now) begin
                push_frame(cfg_420, int'(cfg_mcu_count));
                exp_busy        = 1'b1;
                iss             = 0;
                acc             = 0;
                rel             = 0;
                fr_acc          = 0;
                fr_last         = 0;
                fr_rel          = 0;
                fr_hist[0]      = 0;
                fr_hist[1]      = 0;
                fr_hist[2]      = 0;
                fr_first_cnt    = -1;
                fr_first_chroma = -1;
            end
            prev_hold   = q_valid && q_hold;
            prev_cnt    = q_cnt;
            prev_chroma = q_chroma;
            prev_last   = q_last_mcu;
            prev_data   = {q[1], q[0]};
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame(input logic is420, input int mcu_m1, input int hold, input int gap);
        hold_pct      = hold;
        gap_cfg       = gap;
        cfg_420       = is420;
        cfg_mcu_count = 16'(mcu_m1);
        start         = 1'b1;
        tick();
        start         = 1'b0;
    endtask

    task automatic wait_frame(output int cyc);
        cyc = 1;
        while (exp_busy && cyc < 20000) begin
            tick();
            cyc++;
        end
        check("frame_timeout", 32'(exp_busy), 32'd0);
        repeat (3) tick();
    endtask

    initial begin
        int cyc;
        salt          = $urandom;
        reset         = 1'b1;
        start         = 1'b0;
        cfg_420       = 1'b0;
        cfg_mcu_count = 16'd0;
        blk_avail     = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (2) tick();

        // 4:4:4 single MCU, no stalls.
        start_frame(1'b0, 0, 0, 0);
        wait_frame(cyc);
        check("t1_pairs", 32'(fr_acc), 32'd96);
        check("t1_last_pairs", 32'(fr_last), 32'd32);
        check("t1_releases", 32'(fr_rel), 32'd3);
        check("t1_hist_y", 32'(fr_hist[0]), 32'd32);
        check("t1_hist_cr", 32'(fr_hist[2]), 32'd32);
        check("t1_first_cnt", 32'(fr_first_cnt), 32'd0);
        check("t1_cycles_ok", 32'(cyc <= 109), 32'd1);

        // 4:2:0 two MCUs, no stalls.
        start_frame(1'b1, 1, 0, 0);
        wait_frame(cyc);
        check("t2_pairs", 32'(fr_acc), 32'd384);
        check("t2_last_pairs", 32'(fr_last), 32'd32);
        check("t2_releases", 32'(fr_rel), 32'd12);
        check("t2_hist_y", 32'(fr_hist[0]), 32'd256);
        check("t2_hist_cb", 32'(fr_hist[1]), 32'd64);

        // 4:2:0 four MCUs under 50% random hold.
        start_frame(1'b1, 3, 50, 0);
        wait_frame(cyc);
        check("t3_pairs", 32'(fr_acc), 32'd768);
        check("t3_releases", 32'(fr_rel), 32'd24);
        check("t3_last_pairs", 32'(fr_last), 32'd32);

        // Bank refill gap of 10 cycles after every release.
        start_frame(1'b0, 1, 20, 10);
        wait_frame(cyc);
        repeat (10) tick();
        check("t4_pairs", 32'(fr_acc), 32'd192);
        check("t4_releases", 32'(fr_rel), 32'd6);

        // Reset at pair 17 of block 2, then a fresh frame.
        start_frame(1'b1, 1, 0, 0);
        cyc = 0;
        while (fr_acc < 81 && cyc < 2000) begin
            tick();
            cyc++;
        end
        check("t5_reach_pair", 32'(fr_acc), 32'd81);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        repeat (4) tick();
        check("t5_releases_before_rst", 32'(fr_rel), 32'd2);
        start_frame(1'b0, 0, 30, 0);
        wait_frame(cyc);
        check("t5_new_first_cnt", 32'(fr_first_cnt), 32'd0);
        check("t5_new_first_chroma", 32'(fr_first_chroma), 32'd0);
        check("t5_new_pairs", 32'(fr_acc), 32'd96);

        // start while busy with a different format is ignored.
        start_frame(1'b0, 1, 25, 0);
        repeat (20) tick();
        cfg_420       = 1'b1;
        cfg_mcu_count = 16'd5;
        start         = 1'b1;
        tick();
        start         = 1'b0;
        wait_frame(cyc);
        check("t6_pairs", 32'(fr_acc), 32'd192);
        check("t6_releases", 32'(fr_rel), 32'd6);
        check("t6_hist_cb", 32'(fr_hist[1]), 32'd64);
        check("t6_hist_cr", 32'(fr_hist[2]), 32'd64);
        check("t6_idle_busy", 32'(busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, got running required finished");
        $fatal(1, "watchdog");
    end

endmodule
